// File: rtl/tri_sched_pkg.sv
// Shared types and helpers for the lower-triangular index scheduler.
// Define TRI_SCHED_INCLUDE_DIAG_EN to include the diagonal (col <= row) in the walk.
package tri_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } tri_sched_state_t;

    localparam int unsigned TRI_SCHED_MAX_N = 16;

`ifdef TRI_SCHED_INCLUDE_DIAG_EN
    localparam bit TRI_SCHED_DIAG = 1'b1;
`else
    localparam bit TRI_SCHED_DIAG = 1'b0;
`endif

    // Number of elements produced for an n x n walk in this build.
    function automatic int unsigned tri_walk_len(input int unsigned n);
        if (n == 0) begin
            return 0;
        end
        if (TRI_SCHED_DIAG) begin
            return (n * (n + 1)) / 2;
        end
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/tri_index_scheduler_if.sv
// Control and index-stream bundle of the triangular scheduler.
// slave is the scheduler side, master the controlling/consuming side.
interface tri_index_scheduler_if #(
    parameter int unsigned MAX_N = 16,
    parameter int unsigned IDX_W = $clog2(MAX_N),
    parameter int unsigned DIM_W = $clog2(MAX_N + 1)
);

    logic             start;
    logic [DIM_W-1:0] n_rows;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             row_first;
    logic             row_last;
    logic             last;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output n_rows,
        output abort,
        output out_ready,
        input  out_valid,
        input  row,
        input  col,
        input  row_first,
        input  row_last,
        input  last,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  n_rows,
        input  abort,
        input  out_ready,
        output out_valid,
        output row,
        output col,
        output row_first,
        output row_last,
        output last,
        output busy,
        output done
    );

endinterface

// File: rtl/counter_up_to.sv
// Up-counter that wraps to zero after reaching a run-time bound.
module counter_up_to #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         up,
    input  logic [W-1:0] last,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (up) begin
            count_d = (count_q == last) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tri_index_scheduler.sv
// Row-major lower-triangular (row, col) walk with start/done and valid/ready flow control.
// TRI_SCHED_INCLUDE_DIAG_EN selects whether the diagonal is part of the walk.
module tri_index_scheduler
    import tri_sched_pkg::*;
#(
    parameter int unsigned MAX_N = TRI_SCHED_MAX_N,
    parameter int unsigned IDX_W = $clog2(MAX_N),
    parameter int unsigned DIM_W = $clog2(MAX_N + 1)
) (
    input logic               clk,
    input logic               rst,
    tri_index_scheduler_if.slave bus
);

    localparam logic [DIM_W-1:0] MaxNDim  = DIM_W'(MAX_N);
    localparam logic [IDX_W-1:0] RowStart = IDX_W'(TRI_SCHED_DIAG ? 0 : 1);

    tri_sched_state_t state_q;
    logic [DIM_W-1:0] n_q;
    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] col;
    logic             out_valid_q;
    logic             row_first_q;
    logic             row_last_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    logic             hs;
    logic             walk_ok;
    logic             col_clr;
    logic             col_wrap;
    logic [IDX_W-1:0] row_end;
    logic [IDX_W-1:0] row_nxt;
    logic [IDX_W-1:0] col_nxt;
    logic [IDX_W-1:0] row_end_nxt;
    logic [DIM_W-1:0] n_nxt;
    logic             first_nxt;
    logic             rlast_nxt;
    logic             last_nxt;

    assign hs      = out_valid_q & bus.out_ready;
    assign col_clr = (state_q == StIdle) & bus.start & ~bus.abort;

    // Empty walks skip RUN entirely but still produce a done pulse.
    assign walk_ok = (bus.n_rows != '0) && (bus.n_rows <= MaxNDim) &&
                     (TRI_SCHED_DIAG || (bus.n_rows != DIM_W'(1)));

    // Index and flag values for the element presented after the next accepted step:
    // the first element when starting from IDLE, otherwise the successor of the current one.
    always_comb begin
        row_end  = TRI_SCHED_DIAG ? row_q : row_q - 1'b1;
        col_wrap = (col == row_end);
        n_nxt    = n_q;
        row_nxt  = row_q;
        col_nxt  = col + 1'b1;
        if (state_q == StIdle) begin
            n_nxt   = bus.n_rows;
            row_nxt = RowStart;
            col_nxt = '0;
        end else if (col_wrap) begin
            row_nxt = row_q + 1'b1;
            col_nxt = '0;
        end
        row_end_nxt = TRI_SCHED_DIAG ? row_nxt : row_nxt - 1'b1;
        first_nxt   = (col_nxt == '0);
        rlast_nxt   = (col_nxt == row_end_nxt);
        last_nxt    = rlast_nxt && (DIM_W'(row_nxt) == n_nxt - 1'b1);
    end

    counter_up_to #(
        .W(IDX_W)
    ) u_col_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (col_clr),
        .up   (hs & ~bus.abort),
        .last (row_end),
        .count(col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
                row_first_q <= 1'b0;
                row_last_q  <= 1'b0;
                last_q      <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            n_q    <= bus.n_rows;
                            busy_q <= 1'b1;
                            if (walk_ok) begin
                                state_q     <= StRun;
                                out_valid_q <= 1'b1;
                                row_q       <= row_nxt;
                                row_first_q <= first_nxt;
                                row_last_q  <= rlast_nxt;
                                last_q      <= last_nxt;
                            end else begin
                                state_q <= StFin;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (hs) begin
                            if (last_q) begin
                                // Row stays at n_rows-1 so the counter never passes its bound.
                                state_q     <= StFin;
                                out_valid_q <= 1'b0;
                                row_first_q <= 1'b0;
                                row_last_q  <= 1'b0;
                                last_q      <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                row_q       <= row_nxt;
                                row_first_q <= first_nxt;
                                row_last_q  <= rlast_nxt;
                                last_q      <= last_nxt;
                            end
                        end
                    end
                    StFin: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.row       = row_q;
    assign bus.col       = col;
    assign bus.row_first = row_first_q;
    assign bus.row_last  = row_last_q;
    assign bus.last      = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tri_index_scheduler.sv
// Scoreboard bench for tri_index_scheduler: stimulus pushes expected elements,
// a negedge monitor pops and compares on every handshake.
module tb_tri_index_scheduler;
    import tri_sched_pkg::*;

    localparam int unsigned MaxN = 16;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic       first;
        logic       rlast;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tri_index_scheduler_if #(.MAX_N(MaxN)) bus ();

    tri_index_scheduler #(
        .MAX_N(MaxN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   checks       = 0;
    int   failures     = 0;
    int   cyc          = 0;
    int   hs_cnt       = 0;
    int   done_cnt     = 0;
    int   valid_cycles = 0;
    int   last_hs_cyc  = -10;
    bit   hs_since_start = 1'b0;
    bit   stalled      = 1'b0;
    exp_t held;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t cur();
        return {bus.row, bus.col, bus.row_first, bus.row_last, bus.last};
    endfunction

    function automatic exp_t mk(input int r, input int c, input bit f, input bit rl, input bit la);
        exp_t e;
        e.row   = 4'(r);
        e.col   = 4'(c);
        e.first = f;
        e.rlast = rl;
        e.last  = la;
        return e;
    endfunction

    // Reference walk: nested row/col loops over the triangle.
    task automatic push_walk(input int n);
        int rs;
        int re;
        rs = TRI_SCHED_DIAG ? 0 : 1;
        if (n < 1 || n > int'(MaxN)) return;
        for (int r = rs; r < n; r++) begin
            re = TRI_SCHED_DIAG ? r : r - 1;
            for (int c = 0; c <= re; c++) begin
                exp_q.push_back(mk(r, c, c == 0, c == re, (c == re) && (r == n - 1)));
            end
        end
    endtask

    task automatic push_table();
`ifdef TRI_SCHED_INCLUDE_DIAG_EN
        exp_q.push_back(mk(0, 0, 1, 1, 0));
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 1, 0, 1, 0));
        exp_q.push_back(mk(2, 0, 1, 0, 0));
        exp_q.push_back(mk(2, 1, 0, 0, 0));
        exp_q.push_back(mk(2, 2, 0, 1, 0));
        exp_q.push_back(mk(3, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 1, 0, 0, 0));
        exp_q.push_back(mk(3, 2, 0, 0, 0));
        exp_q.push_back(mk(3, 3, 0, 1, 1));
`else
        exp_q.push_back(mk(1, 0, 1, 1, 0));
        exp_q.push_back(mk(2, 0, 1, 0, 0));
        exp_q.push_back(mk(2, 1, 0, 1, 1));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_row"},       32'(bus.row), 0);
        check({tag, "_col"},       32'(bus.col), 0);
        check({tag, "_row_first"}, 32'(bus.row_first), 0);
        check({tag, "_row_last"},  32'(bus.row_last), 0);
        check({tag, "_last"},      32'(bus.last), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_done"},      32'(bus.done), 0);
    endtask

    // Monitor: compares every handshake, checks stall stability and done timing.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            stalled        = 1'b0;
            hs_since_start = 1'b0;
        end else begin
            if (bus.out_valid) begin
                valid_cycles++;
                if (stalled) check("stall_hold", 32'(cur()), 32'(held));
                if (bus.out_ready && !bus.abort) begin
                    hs_cnt++;
                    hs_since_start = 1'b1;
                    last_hs_cyc    = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_element: got %0h expected none", cur());
                    end else begin
                        check("element", 32'(cur()), 32'(exp_q.pop_front()));
                    end
                end
                stalled = !bus.out_ready && !bus.abort;
                held    = cur();
            end else begin
                stalled = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_at_done", 32'(bus.busy), 1);
                if (hs_since_start) check("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
                hs_since_start = 1'b0;
            end
        end
    end

    // Starts a walk from posedge+1 and waits (bounded) for done.
    task automatic run_walk(input int n, input bit stall);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        bus.start     = 1'b1;
        bus.n_rows    = 5'(n);
        bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            if (stall) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("done_seen", 32'(ok), 1);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("busy_after_done", 32'(bus.busy), 0);
        check("done_single_pulse", 32'(bus.done), 0);
        exp_q.delete();
        bus.out_ready = 1'b1;
    endtask

    task automatic run_empty(input int n);
        int v0;
        v0 = valid_cycles;
        run_walk(n, 1'b0);
        check("empty_no_valid", 32'(valid_cycles), 32'(v0));
    endtask

    // Bounded wait for a number of handshakes since h0.
    task automatic wait_hs(input int h0, input int k, input string name);
        for (int c = 0; c < 100 && (hs_cnt - h0) < k; c++) begin
            @(posedge clk); #1;
        end
        check(name, 32'(hs_cnt - h0), 32'(k));
    endtask

    initial begin
        int h0;
        int d0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.n_rows    = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        push_table();
        run_walk(TRI_SCHED_DIAG ? 4 : 3, 1'b0);

        push_walk(5);
        run_walk(5, 1'b0);
        push_walk(5);
        run_walk(5, 1'b1);
        push_walk(int'(MaxN));
        run_walk(int'(MaxN), 1'b0);

        run_empty(0);
        run_empty(int'(MaxN) + 1);
        if (!TRI_SCHED_DIAG) run_empty(1);

        // Start while busy is ignored: second start mid-walk must not disturb the sequence.
        push_walk(3);
        h0 = hs_cnt;
        bus.start  = 1'b1;
        bus.n_rows = 5'd3;
        @(posedge clk); #1;
        bus.n_rows = 5'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 50 && bus.busy; c++) begin
            @(posedge clk); #1;
        end
        check("busy_start_ignored_drained", 32'(exp_q.size()), 0);
        exp_q.delete();

        // Abort on the fourth element of an n=4 walk.
        push_walk(4);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        h0 = hs_cnt;
        d0 = done_cnt;
        bus.start  = 1'b1;
        bus.n_rows = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_hs(h0, 3, "abort_reach_elem4");
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_queue", 32'(exp_q.size()), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        exp_q.delete();
        push_walk(4);
        run_walk(4, 1'b0);

        // Asynchronous reset between clock edges.
        push_walk(5);
        h0 = hs_cnt;
        bus.start  = 1'b1;
        bus.n_rows = 5'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_hs(h0, 2, "rst_reach_elem3");
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        push_walk(5);
        run_walk(5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
